// File: rtl/axi4_lite_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_initiator
//  Description : Converts one native valid/ready memory request into an
//                AXI4-lite read or write and returns the result. One
//                transaction outstanding; AW and W handshake independently.
//                Optional response watchdog: define AXI_INITIATOR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_error,
    output logic        o_mem_axi_awvalid,
    input  logic        i_mem_axi_awready,
    output logic [31:0] o_mem_axi_awaddr,
    output logic [2:0]  o_mem_axi_awprot,
    output logic        o_mem_axi_wvalid,
    input  logic        i_mem_axi_wready,
    output logic [31:0] o_mem_axi_wdata,
    output logic [3:0]  o_mem_axi_wstrb,
    input  logic        i_mem_axi_bvalid,
    output logic        o_mem_axi_bready,
    output logic        o_mem_axi_arvalid,
    input  logic        i_mem_axi_arready,
    output logic [31:0] o_mem_axi_araddr,
    output logic [2:0]  o_mem_axi_arprot,
    input  logic        i_mem_axi_rvalid,
    output logic        o_mem_axi_rready,
    input  logic [31:0] i_mem_axi_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;
    logic   r_aw_done;
    logic   r_w_done;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_all;
    logic w_w_all;
    logic w_abort;

    // Reject out-of-range watchdog limits at elaboration time.
    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 2..65535");
        end
    endgenerate

    assign w_aw_hs  = o_mem_axi_awvalid & i_mem_axi_awready;
    assign w_w_hs   = o_mem_axi_wvalid  & i_mem_axi_wready;
    assign w_b_hs   = o_mem_axi_bready  & i_mem_axi_bvalid;
    assign w_ar_hs  = o_mem_axi_arvalid & i_mem_axi_arready;
    assign w_r_hs   = o_mem_axi_rready  & i_mem_axi_rvalid;
    // A write channel counts as finished if it completed earlier or completes now.
    assign w_aw_all = r_aw_done | w_aw_hs;
    assign w_w_all  = r_w_done  | w_w_hs;

    // Write protection is always unprivileged, secure, data.
    assign o_mem_axi_awprot = 3'b000;

`ifdef AXI_INITIATOR_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        w_busy;
    logic        w_any_hs;

    assign w_busy   = (r_state == S_RADDR) || (r_state == S_RDATA) ||
                      (r_state == S_WRITE) || (r_state == S_WRESP);
    // Any forward progress in the current state defers the abort.
    assign w_any_hs = ((r_state == S_RADDR) && w_ar_hs) ||
                      ((r_state == S_RDATA) && w_r_hs)  ||
                      ((r_state == S_WRITE) && (w_aw_hs || w_w_hs)) ||
                      ((r_state == S_WRESP) && w_b_hs);
    assign w_abort  = w_busy && !w_any_hs &&
                      (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared while idle, counts every busy cycle of a transaction.
    always_ff @(posedge clk) begin
        if (!resetn || r_state == S_IDLE) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_busy) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Transaction sequencer with registered native and AXI outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state           <= S_IDLE;
            r_aw_done         <= 1'b0;
            r_w_done          <= 1'b0;
            o_mem_ready       <= 1'b0;
            o_mem_rdata       <= 32'd0;
            o_mem_error       <= 1'b0;
            o_mem_axi_awvalid <= 1'b0;
            o_mem_axi_awaddr  <= 32'd0;
            o_mem_axi_wvalid  <= 1'b0;
            o_mem_axi_wdata   <= 32'd0;
            o_mem_axi_wstrb   <= 4'd0;
            o_mem_axi_bready  <= 1'b0;
            o_mem_axi_arvalid <= 1'b0;
            o_mem_axi_araddr  <= 32'd0;
            o_mem_axi_arprot  <= 3'd0;
            o_mem_axi_rready  <= 1'b0;
        end else begin
            o_mem_ready <= 1'b0;
            if (w_abort) begin
                o_mem_axi_awvalid <= 1'b0;
                o_mem_axi_wvalid  <= 1'b0;
                o_mem_axi_bready  <= 1'b0;
                o_mem_axi_arvalid <= 1'b0;
                o_mem_axi_rready  <= 1'b0;
                o_mem_rdata       <= 32'hDEAD_BEEF;
                o_mem_error       <= 1'b1;
                o_mem_ready       <= 1'b1;
                r_state           <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        o_mem_error <= 1'b0;
                        if (i_mem_valid) begin
                            if (i_mem_wstrb == 4'b0000) begin
                                o_mem_axi_araddr  <= i_mem_addr;
                                o_mem_axi_arprot  <= {i_mem_instr, 2'b00};
                                o_mem_axi_arvalid <= 1'b1;
                                r_state           <= S_RADDR;
                            end else begin
                                o_mem_axi_awaddr  <= i_mem_addr;
                                o_mem_axi_wdata   <= i_mem_wdata;
                                o_mem_axi_wstrb   <= i_mem_wstrb;
                                o_mem_axi_awvalid <= 1'b1;
                                o_mem_axi_wvalid  <= 1'b1;
                                r_aw_done         <= 1'b0;
                                r_w_done          <= 1'b0;
                                r_state           <= S_WRITE;
                            end
                        end
                    end
                    S_RADDR: begin
                        if (w_ar_hs) begin
                            o_mem_axi_arvalid <= 1'b0;
                            o_mem_axi_rready  <= 1'b1;
                            r_state           <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        if (w_r_hs) begin
                            o_mem_rdata      <= i_mem_axi_rdata;
                            o_mem_axi_rready <= 1'b0;
                            o_mem_ready      <= 1'b1;
                            r_state          <= S_DONE;
                        end
                    end
                    S_WRITE: begin
                        if (w_aw_hs) begin
                            o_mem_axi_awvalid <= 1'b0;
                            r_aw_done         <= 1'b1;
                        end
                        if (w_w_hs) begin
                            o_mem_axi_wvalid <= 1'b0;
                            r_w_done         <= 1'b1;
                        end
                        if (w_aw_all && w_w_all) begin
                            o_mem_axi_bready <= 1'b1;
                            r_state          <= S_WRESP;
                        end
                    end
                    S_WRESP: begin
                        if (w_b_hs) begin
                            o_mem_axi_bready <= 1'b0;
                            o_mem_ready      <= 1'b1;
                            r_state          <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_initiator
//  Description : Bench for axi4_lite_initiator: AXI4-lite responder memory
//                with programmable stalls, request-level reference memory,
//                and a per-cycle checker of the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_initiator;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready, mem_error;
    logic [31:0] mem_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;

    axi4_lite_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .i_mem_valid(mem_valid), .i_mem_instr(mem_instr), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .i_mem_wstrb(mem_wstrb),
        .o_mem_ready(mem_ready), .o_mem_rdata(mem_rdata), .o_mem_error(mem_error),
        .o_mem_axi_awvalid(awvalid), .i_mem_axi_awready(awready),
        .o_mem_axi_awaddr(awaddr), .o_mem_axi_awprot(awprot),
        .o_mem_axi_wvalid(wvalid), .i_mem_axi_wready(wready),
        .o_mem_axi_wdata(wdata), .o_mem_axi_wstrb(wstrb),
        .i_mem_axi_bvalid(bvalid), .o_mem_axi_bready(bready),
        .o_mem_axi_arvalid(arvalid), .i_mem_axi_arready(arready),
        .o_mem_axi_araddr(araddr), .o_mem_axi_arprot(arprot),
        .i_mem_axi_rvalid(rvalid), .o_mem_axi_rready(rready),
        .i_mem_axi_rdata(rdata)
    );

    // ---------------- shared data helpers ----------------
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 64) return 32'h1234_5678;      // byte address 0x100
        if (i == 16) return 32'h1111_2222;      // byte address 0x40
        return {b, 8'h5A, b, 8'hA5};
    endfunction

    // ---------------- AXI4-lite responder memory ----------------
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 1, r_dly = 1;
    bit r_never = 1'b0;
    bit do_preload = 1'b1;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic got_aw = 1'b0, got_w = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] p_addr = 32'd0, p_data = 32'd0, r_addr = 32'd0;
    logic [3:0]  p_strb = 4'd0;
    logic [31:0] smem [256];
    logic        bvalid_q = 1'b0, rvalid_q = 1'b0;
    logic [31:0] rdata_q = 32'd0;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid  && (w_cnt  >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign bvalid  = bvalid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
        end
        if (!resetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            bvalid_q <= 1'b0; rvalid_q <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) begin got_aw <= 1'b1; p_addr <= awaddr; end
            if (wvalid && wready) begin got_w <= 1'b1; p_data <= wdata; p_strb <= wstrb; end
            if (got_aw && got_w) begin
                smem[p_addr[9:2]] <= merge(smem[p_addr[9:2]], p_data, p_strb);
                got_aw <= 1'b0; got_w <= 1'b0;
                if (b_dly <= 1) bvalid_q <= 1'b1;
                else begin b_pend <= 1'b1; b_cnt <= b_dly - 1; end
            end
            if (b_pend) begin
                if (b_cnt <= 1) begin bvalid_q <= 1'b1; b_pend <= 1'b0; end
                else b_cnt <= b_cnt - 1;
            end
            if (bvalid_q && bready) bvalid_q <= 1'b0;
            if (arvalid && arready && !r_never) begin
                r_pend <= 1'b1; r_addr <= araddr; r_cnt <= r_dly;
            end
            if (r_pend) begin
                if (r_cnt <= 1) begin
                    rvalid_q <= 1'b1; rdata_q <= smem[r_addr[9:2]]; r_pend <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
            if (rvalid_q && rready) rvalid_q <= 1'b0;
        end
    end

    // ---------------- reference model and bookkeeping ----------------
    logic [31:0] refm [256];
    int n_vec = 0, n_bad = 0;
    int n_done = 0, req_issued = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int mon_cyc = 0, aw_cyc = 0, w_cyc = 0;
    logic [2:0]  last_arprot = 3'd0;
    logic [31:0] held_rdata = 32'd0;
    logic        exp_read = 1'b0, exp_instr = 1'b0, exp_abort = 1'b0;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, exp_rdata = 32'd0;
    logic [3:0]  exp_wstrb = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle checker, sampling on the falling edge.
    task automatic monitor();
        logic pv_aw = 1'b0, pv_awhs = 1'b0, pv_w = 1'b0, pv_whs = 1'b0;
        logic pv_ar = 1'b0, pv_arhs = 1'b0, prev_rst = 1'b1;
        logic [31:0] p_awa = 32'd0, p_wd = 32'd0, p_ara = 32'd0;
        logic [3:0]  p_ws = 4'd0;
        logic [2:0]  p_arp = 3'd0;
        logic        aborting;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!resetn || prev_rst) begin
                if (!resetn) held_rdata = 32'd0;
                prev_rst = !resetn;
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
                pv_aw = 1'b0; pv_w = 1'b0; pv_ar = 1'b0;
                continue;
            end
            aborting = mem_ready && mem_error;
            if (!aborting) begin
                if (pv_aw && !pv_awhs) begin
                    chk("awvalid_held", 32'(awvalid), 32'd1);
                    chk("awaddr_stable", awaddr, p_awa);
                end
                if (pv_w && !pv_whs) begin
                    chk("wvalid_held", 32'(wvalid), 32'd1);
                    chk("wdata_stable", wdata, p_wd);
                    chk("wstrb_stable", 32'(wstrb), 32'(p_ws));
                end
                if (pv_ar && !pv_arhs) begin
                    chk("arvalid_held", 32'(arvalid), 32'd1);
                    chk("araddr_stable", araddr, p_ara);
                    chk("arprot_stable", 32'(arprot), 32'(p_arp));
                end
            end
            if (bready) chk("bready_after_aw_and_w", 32'({n_aw == 1, n_w == 1}), 32'd3);
            if (awvalid && awready) begin
                n_aw++; aw_cyc = mon_cyc;
                chk("aw_in_write", 32'(!exp_read), 32'd1);
                chk("awaddr", awaddr, exp_addr);
                chk("awprot", 32'(awprot), 32'd0);
            end
            if (wvalid && wready) begin
                n_w++; w_cyc = mon_cyc;
                chk("wdata", wdata, exp_wdata);
                chk("wstrb", 32'(wstrb), 32'(exp_wstrb));
            end
            if (arvalid && arready) begin
                n_ar++; last_arprot = arprot;
                chk("ar_in_read", 32'(exp_read), 32'd1);
                chk("araddr", araddr, exp_addr);
                chk("arprot", 32'(arprot), 32'({exp_instr, 2'b00}));
            end
            if (bvalid && bready) n_b++;
            if (rvalid && rready) n_r++;
            if (mem_ready) begin
                chk("ready_one_per_request", 32'(n_done + 1), 32'(req_issued));
                n_done++;
                chk("mem_error", 32'(mem_error), 32'(exp_abort));
                if (exp_abort) begin
                    chk("abort_rdata", mem_rdata, 32'hDEAD_BEEF);
                    held_rdata = 32'hDEAD_BEEF;
                end else if (exp_read) begin
                    chk("read_data", mem_rdata, exp_rdata);
                    chk("read_hs_counts", 32'({n_ar[3:0], n_r[3:0], n_aw[3:0], n_w[3:0], n_b[3:0]}),
                        32'h11000);
                    held_rdata = exp_rdata;
                end else begin
                    chk("write_hs_counts", 32'({n_ar[3:0], n_r[3:0], n_aw[3:0], n_w[3:0], n_b[3:0]}),
                        32'h00111);
                end
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
            end else begin
                chk("rdata_held", mem_rdata, held_rdata);
            end
            pv_aw = awvalid; pv_awhs = awvalid && awready; p_awa = awaddr;
            pv_w = wvalid; pv_whs = wvalid && wready; p_wd = wdata; p_ws = wstrb;
            pv_ar = arvalid; pv_arhs = arvalid && arready; p_ara = araddr; p_arp = arprot;
        end
    endtask

    // Issue one request; lat = edges from the sampling edge to mem_ready.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic ins, input logic abort, output int lat);
        int base, n;
        exp_addr = a; exp_wdata = d; exp_wstrb = s; exp_instr = ins;
        exp_read = (s == 4'd0); exp_abort = abort;
        exp_rdata = refm[a[9:2]];
        if (s != 4'd0) refm[a[9:2]] = merge(refm[a[9:2]], d, s);
        base = n_done;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
        req_issued++;
        n = 0;
        while (n_done == base && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (n_done == base) chk("request_completed", 32'd0, 32'd1);
        lat = n - 2;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int lat, k;
        logic [31:0] a, d;
        logic [3:0] s;
        for (int i = 0; i < 256; i++) refm[i] = init_word(i);
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        do_preload = 1'b0;
        chk("reset_ctrl_outputs",
            32'({mem_ready, mem_error, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        chk("reset_addr_data", awaddr | araddr | wdata | 32'({wstrb, awprot, arprot}), 32'd0);
        resetn = 1'b1;

        // Zero-wait instruction read of a preloaded word.
        do_req(32'h0000_0100, 32'd0, 4'b0000, 1'b1, 1'b0, lat);
        chk("read_latency", 32'(lat), 32'd3);
        chk("read_data_literal", mem_rdata, 32'h1234_5678);
        chk("arprot_literal", 32'(last_arprot), 32'd4);

        // Zero-wait write.
        do_req(32'h0000_0080, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, lat);
        chk("write_latency", 32'(lat), 32'd3);

        // W channel three cycles behind AW; partial strobe.
        w_dly = 3;
        do_req(32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1'b0, lat);
        chk("aw_then_w_gap", 32'(w_cyc - aw_cyc), 32'd3);
        w_dly = 0;
        do_req(32'h0000_0040, 32'd0, 4'b0000, 1'b0, 1'b0, lat);
        chk("partial_write_literal", mem_rdata, 32'h1111_A5A5);

        // High address write; aliases word 0 in the bench memory.
        do_req(32'h1000_0000, 32'h0000_0041, 4'b1111, 1'b0, 1'b0, lat);
        do_req(32'h1000_0000, 32'd0, 4'b0000, 1'b0, 1'b0, lat);
        chk("high_addr_literal", mem_rdata, 32'h0000_0041);

        // Reset while in WRITE with only AW done.
        w_dly = 50;
        exp_addr = 32'h0000_0020; exp_wdata = 32'h7777_7777; exp_wstrb = 4'b1111;
        exp_read = 1'b0; exp_abort = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = exp_addr; mem_wdata = exp_wdata; mem_wstrb = exp_wstrb;
        req_issued++;
        k = 0;
        while (n_aw == 0 && k < 20) begin @(negedge clk); #1; k++; end
        chk("aw_before_reset", 32'(n_aw), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
        @(posedge clk); #1;
        chk("reset_midwrite_valids",
            32'({mem_ready, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        resetn = 1'b1;
        req_issued--;
        w_dly = 0;
        do_req(32'h0000_0020, 32'h0BAD_F00D, 4'b1100, 1'b0, 1'b0, lat);
        chk("post_reset_write_latency", 32'(lat), 32'd3);
        do_req(32'h0000_0020, 32'd0, 4'b0000, 1'b0, 1'b0, lat);
        chk("post_reset_read_literal", mem_rdata, 32'h0BAD_08A5);

        // Mixed requests with random stalls.
        for (int i = 0; i < 300; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(1, 3); r_dly = $urandom_range(1, 3);
            a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 28);
            d = $urandom();
            s = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            do_req(a, d, s, (s == 4'd0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, lat);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 1; r_dly = 1;

`ifdef AXI_INITIATOR_TIMEOUT_EN
        // Read response never arrives: watchdog abort.
        r_never = 1'b1;
        do_req(32'h0000_0100, 32'd0, 4'b0000, 1'b0, 1'b1, lat);
        chk("abort_latency", 32'(lat), 32'd16);
        chk("abort_rdata_literal", mem_rdata, 32'hDEAD_BEEF);
        r_never = 1'b0;
        do_req(32'h0000_0100, 32'd0, 4'b0000, 1'b0, 1'b0, lat);
        chk("after_abort_read", mem_rdata, 32'h1234_5678);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
